// File: rtl/router_mem_arbiter.sv
// Round-robin burst arbiter sharing one single-port packet buffer.
// Holds the grant for a whole burst and walks the per-beat address.
module router_mem_arbiter #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_WIDTH    = 10,
  parameter int LEN_WIDTH     = 5,
  parameter int NUMBER_PACKET = 19
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0]  req_len,
  input  logic                            mem_ready,
  output logic [NUM_PORTS-1:0]            gnt,
  output logic                            read_gnt,
  output logic                            write_gnt,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [NUM_PORTS-1:0]            done
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state_q, state_d;
  logic [NUM_PORTS-1:0]    gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]    done_q, done_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           win_q, win_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic                    en_q, en_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;

  logic                    hit;
  logic [PW-1:0]           sel;
  logic [PW-1:0]           cand;
  logic [NUM_PORTS-1:0]    req_m;
  logic [LEN_WIDTH-1:0]    sel_len;

  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    return PW'(s % NUM_PORTS);
  endfunction

  // A port is not eligible in the cycle its done pulse is high.
  assign req_m = req & ~done_q;

  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = wrap_add(ptr_q, i);
      if (!hit && req_m[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
  end

  assign sel_len = req_len[sel*LEN_WIDTH +: LEN_WIDTH];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    en_d    = en_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d   = BURST;
          gnt_d     = '0;
          gnt_d[sel] = 1'b1;
          win_d     = sel;
          we_d      = req_we[sel];
          addr_d    = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
          cnt_d     = (sel_len == '0) ?
                      LEN_WIDTH'(NUMBER_PACKET) : sel_len;
          en_d      = 1'b1;
          rd_d      = ~req_we[sel];
          wr_d      = req_we[sel];
        end
      end
      BURST: begin
        if (!req[win_q]) begin
          state_d = IDLE;
          ptr_d   = wrap_add(win_q, 1);
        end else if (en_q && mem_ready) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d       = IDLE;
            done_d[win_q] = 1'b1;
            ptr_d         = wrap_add(win_q, 1);
          end
        end
        if (state_d == IDLE) begin
          gnt_d  = '0;
          en_d   = 1'b0;
          rd_d   = 1'b0;
          wr_d   = 1'b0;
          we_d   = 1'b0;
          addr_d = '0;
          cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      en_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      en_q    <= en_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign read_gnt  = rd_q;
  assign write_gnt = wr_q;

endmodule
